// File: rtl/mem_port_arbiter.sv
// Serializes the two memory-stage lanes onto one dcache port, lane 0 first, and returns both load results together.
// Optional store-to-load forwarding from lane 0 to lane 1 is enabled by defining MEM_ARB_ST_LD_FWD_EN.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TYPE_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [1:0]            req_rd,
  input  logic [1:0]            req_wr,
  input  logic [2*TYPE_W-1:0]   req_type,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic                  stall,
  output logic                  out_valid,
  output logic [2*DATA_W-1:0]   out_rdata,
  output logic                  dc_req,
  output logic                  dc_we,
  output logic [TYPE_W-1:0]     dc_type,
  output logic [ADDR_W-1:0]     dc_addr,
  output logic [DATA_W-1:0]     dc_wdata,
  input  logic                  dc_ack,
  input  logic [DATA_W-1:0]     dc_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE0, ISSUE1, DONE} state_t;

  localparam logic [TYPE_W-1:0] TYPE_WORD = TYPE_W'(2);

  state_t state, next_state;

  logic [1:0]          b_rd, b_wr;
  logic [2*TYPE_W-1:0] b_type;
  logic [2*ADDR_W-1:0] b_addr;
  logic [2*DATA_W-1:0] b_wdata;
  logic [DATA_W-1:0]   res0, res1, res0_n, res1_n;
  logic [1:0]          need_in, need_b;
  logic                accept, fwd;

  assign need_in = req_rd | req_wr;
  assign need_b  = b_rd | b_wr;
  assign accept  = ((state == IDLE) || (state == DONE)) && in_valid;

`ifdef MEM_ARB_ST_LD_FWD_EN
  // Lane 1 word load hitting lane 0's word store takes the store data directly.
  assign fwd = b_wr[0] && (b_type[TYPE_W-1:0] == TYPE_WORD) &&
               b_rd[1] && !b_wr[1] && (b_type[2*TYPE_W-1:TYPE_W] == TYPE_WORD) &&
               (b_addr[ADDR_W-1:2] == b_addr[2*ADDR_W-1:ADDR_W+2]);
`else
  assign fwd = 1'b0;
`endif

  always_comb begin
    next_state = state;
    res0_n     = res0;
    res1_n     = res1;
    stall      = 1'b0;
    out_valid  = 1'b0;
    dc_req     = 1'b0;
    dc_we      = 1'b0;
    dc_type    = '0;
    dc_addr    = '0;
    dc_wdata   = '0;
    case (state)
      IDLE, DONE: begin
        out_valid = (state == DONE);
        if (in_valid) begin
          res0_n = '0;
          res1_n = '0;
          if (need_in[0])      next_state = ISSUE0;
          else if (need_in[1]) next_state = ISSUE1;
          else                 next_state = DONE;
        end else begin
          next_state = IDLE;
        end
      end
      ISSUE0: begin
        stall    = 1'b1;
        dc_req   = 1'b1;
        dc_we    = b_wr[0];
        dc_type  = b_type[TYPE_W-1:0];
        dc_addr  = b_addr[ADDR_W-1:0];
        dc_wdata = b_wdata[DATA_W-1:0];
        if (dc_ack) begin
          // A lane with both enables set is treated as a store and reports 0.
          if (b_rd[0] && !b_wr[0]) res0_n = dc_rdata;
          if (fwd) begin
            res1_n     = b_wdata[DATA_W-1:0];
            next_state = DONE;
          end else if (need_b[1]) begin
            next_state = ISSUE1;
          end else begin
            next_state = DONE;
          end
        end
      end
      ISSUE1: begin
        stall    = 1'b1;
        dc_req   = 1'b1;
        dc_we    = b_wr[1];
        dc_type  = b_type[2*TYPE_W-1:TYPE_W];
        dc_addr  = b_addr[2*ADDR_W-1:ADDR_W];
        dc_wdata = b_wdata[2*DATA_W-1:DATA_W];
        if (dc_ack) begin
          if (b_rd[1] && !b_wr[1]) res1_n = dc_rdata;
          next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      b_rd      <= '0;
      b_wr      <= '0;
      b_type    <= '0;
      b_addr    <= '0;
      b_wdata   <= '0;
      res0      <= '0;
      res1      <= '0;
      out_rdata <= '0;
    end else begin
      state <= next_state;
      res0  <= res0_n;
      res1  <= res1_n;
      if (accept) begin
        b_rd    <= req_rd;
        b_wr    <= req_wr;
        b_type  <= req_type;
        b_addr  <= req_addr;
        b_wdata <= req_wdata;
      end
      // Results become visible on entry to DONE and hold until the next DONE.
      if (next_state == DONE) out_rdata <= {res1_n, res0_n};
    end
  end

endmodule
